calc_alu_arbiter: RTL and testbench

Arbitrated sequencer that shares one 4-bit add/sub/mul/div calculator datapath between two requesters. Each requester presents operands and an operator with a valid/ready handshake. The block grants one request at a time (round-robin), registers the operands, executes, and holds a tagged result until the consumer accepts it. It sits between the two operand sources (switch/button front-ends) and the BCD/FND display path.

---
 rtl/calc_alu_arbiter_if.sv | 41 ++++
 rtl/calc_alu_arbiter.sv | 135 +++++++++++++
 tb/tb_calc_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_alu_arbiter_if.sv
// Requester and response handshake bundle for calc_alu_arbiter.
// The slave modport is the arbiter side; the master modport is the side that drives requests and consumes results.
interface calc_alu_arbiter_if;
    logic       i_req0_valid;
    logic [3:0] i_req0_a;
    logic [3:0] i_req0_b;
    logic [1:0] i_req0_op;
    logic       o_req0_ready;

    logic       i_req1_valid;
    logic [3:0] i_req1_a;
    logic [3:0] i_req1_b;
    logic [1:0] i_req1_op;
    logic       o_req1_ready;

    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic       o_rsp_id;
    logic [3:0] o_rsp_result;
    logic       o_rsp_divzero;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
        output o_req0_ready,
        input  i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
        output o_req1_ready,
        output o_rsp_valid,
        input  i_rsp_ready,
        output o_rsp_id, o_rsp_result, o_rsp_divzero
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
        input  o_req0_ready,
        output i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
        input  o_req1_ready,
        input  o_rsp_valid,
        output i_rsp_ready,
        input  o_rsp_id, o_rsp_result, o_rsp_divzero
    );
endinterface

// File: rtl/calc_alu_arbiter.sv
// Two-requester arbiter sharing one 4-bit add/sub/mul/div datapath, round-robin by default.
// Define CALC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
//
// state  | meaning
// IDLE   | waiting for a request; ready asserted toward the granted requester
// EXEC   | computing on the latched operands
// RESP   | result held on the response port until the consumer takes it
module calc_alu_arbiter (
    input  logic               i_clk,
    input  logic               i_reset,
    calc_alu_arbiter_if.slave  bus,
    output logic               o_busy,
    output logic [7:0]         o_op_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [1:0] r_op;
    logic       r_id;
    logic [3:0] r_result;
    logic       r_divzero;
    logic       r_rsp_valid;
    logic       r_busy;
    logic [7:0] r_op_count;

    logic       w_idle;
    logic       w_grant;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_accept;
    logic [7:0] w_prod;
    logic [3:0] w_result;
    logic       w_divzero;

    assign w_idle = (r_state == S_IDLE);

`ifdef CALC_ARB_FIXED_PRIO_EN
    assign w_grant = ~bus.i_req0_valid;
`else
    logic r_last_id;
    // On a tie the requester that did not win last time gets the grant.
    assign w_grant = (bus.i_req0_valid && bus.i_req1_valid) ? ~r_last_id : ~bus.i_req0_valid;
`endif

    assign w_ready0 = w_idle && bus.i_req0_valid && !w_grant;
    assign w_ready1 = w_idle && bus.i_req1_valid && w_grant;
    assign w_accept = w_ready0 || w_ready1;

    assign bus.o_req0_ready  = w_ready0;
    assign bus.o_req1_ready  = w_ready1;
    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_id      = r_id;
    assign bus.o_rsp_result  = r_result;
    assign bus.o_rsp_divzero = r_divzero;
    assign o_busy            = r_busy;
    assign o_op_count        = r_op_count;

    assign w_prod = {4'd0, r_a} * {4'd0, r_b};

    always_comb begin
        w_result  = 4'd0;
        w_divzero = 1'b0;
        case (r_op)
            2'b00: w_result = r_a + r_b;
            2'b01: w_result = r_a - r_b;
            2'b10: w_result = w_prod[3:0];
            default: begin
                if (r_b == 4'd0) begin
                    w_divzero = 1'b1;
                end else begin
                    w_result = r_a / r_b;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_op        <= 2'd0;
            r_id        <= 1'b0;
            r_result    <= 4'd0;
            r_divzero   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= 8'd0;
`ifndef CALC_ARB_FIXED_PRIO_EN
            r_last_id   <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? bus.i_req1_a  : bus.i_req0_a;
                        r_b     <= w_grant ? bus.i_req1_b  : bus.i_req0_b;
                        r_op    <= w_grant ? bus.i_req1_op : bus.i_req0_op;
                        r_id    <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
`ifndef CALC_ARB_FIXED_PRIO_EN
                        r_last_id <= w_grant;
`endif
                    end
                end
                S_EXEC: begin
                    r_result    <= w_result;
                    r_divzero   <= w_divzero;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_alu_arbiter.sv
// Directed self-checking bench for calc_alu_arbiter.
// Expected grant order follows CALC_ARB_FIXED_PRIO_EN when it is defined.
module tb_calc_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] cnt;
    int         errors = 0;
    int         checks = 0;

`ifdef CALC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    calc_alu_arbiter_if bus();

    calc_alu_arbiter dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .bus        (bus),
        .o_busy     (busy),
        .o_op_count (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_req0_valid = 1'b0; bus.i_req0_a = 4'd0; bus.i_req0_b = 4'd0; bus.i_req0_op = 2'd0;
        bus.i_req1_valid = 1'b0; bus.i_req1_a = 4'd0; bus.i_req1_b = 4'd0; bus.i_req1_op = 2'd0;
        bus.i_rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Runs one operation on requester rq with rsp_ready held high; returns the response fields.
    task automatic do_op(input bit rq, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         output logic [3:0] res, output logic dz, output logic rid, output bit to);
        to = 1'b1; res = 4'd0; dz = 1'b0; rid = 1'b0;
        if (rq) begin
            bus.i_req1_a = a; bus.i_req1_b = b; bus.i_req1_op = op; bus.i_req1_valid = 1'b1;
        end else begin
            bus.i_req0_a = a; bus.i_req0_b = b; bus.i_req0_op = op; bus.i_req0_valid = 1'b1;
        end
        bus.i_rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((rq ? bus.o_req1_ready : bus.o_req0_ready) === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick;
        end
        tick;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        if (to) return;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_rsp_valid === 1'b1) begin
                res = bus.o_rsp_result; dz = bus.o_rsp_divzero; rid = bus.o_rsp_id;
                to = 1'b0;
                break;
            end
            tick;
        end
        tick;
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs;
        apply_reset;
        #1;
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.o_rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt); end
        checks++; if (bus.o_rsp_result !== 4'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", bus.o_rsp_result); end
        checks++; if (bus.o_rsp_id !== 1'b0 || bus.o_rsp_divzero !== 1'b0) begin errors++; $display("FAIL reset_id_dz: got id=%b dz=%b want 0 0", bus.o_rsp_id, bus.o_rsp_divzero); end
        checks++; if (bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", bus.o_req0_ready, bus.o_req1_ready); end
    endtask

    task automatic test_basic;
        bus.i_req0_a = 4'd3; bus.i_req0_b = 4'd4; bus.i_req0_op = 2'b00; bus.i_req0_valid = 1'b1;
        #1;
        checks++; if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b%b want 10", bus.o_req0_ready, bus.o_req1_ready); end
        tick;
        bus.i_req0_valid = 1'b0;
        bus.i_req0_a = 4'd15;
        #1;
        checks++; if (busy !== 1'b1 || bus.o_rsp_valid !== 1'b0 || bus.o_req0_ready !== 1'b0) begin errors++; $display("FAIL basic_exec: got busy=%b rv=%b rdy=%b want 1 0 0", busy, bus.o_rsp_valid, bus.o_req0_ready); end
        tick;
        checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid: got %b want 1", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_result !== 4'd7) begin errors++; $display("FAIL basic_result: got %0d want 7", bus.o_rsp_result); end
        checks++; if (bus.o_rsp_id !== 1'b0 || bus.o_rsp_divzero !== 1'b0) begin errors++; $display("FAIL basic_id_dz: got id=%b dz=%b want 0 0", bus.o_rsp_id, bus.o_rsp_divzero); end
        bus.i_rsp_ready = 1'b1;
        tick;
        bus.i_rsp_ready = 1'b0;
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", cnt); end
        checks++; if (bus.o_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got rv=%b busy=%b want 0 0", bus.o_rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        bit exp_gr [4];
        bit gr [4];
        int n_gr = 0;
        int n_rsp = 0;
        exp_gr[0] = 1'b0; exp_gr[1] = !FIXED; exp_gr[2] = 1'b0; exp_gr[3] = !FIXED;
        idle_inputs;
        apply_reset;
        bus.i_req0_a = 4'd1; bus.i_req0_b = 4'd1; bus.i_req0_op = 2'b00; bus.i_req0_valid = 1'b1;
        bus.i_req1_a = 4'd5; bus.i_req1_b = 4'd6; bus.i_req1_op = 2'b00; bus.i_req1_valid = 1'b1;
        bus.i_rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && n_rsp < 4; c++) begin
            if (bus.o_req0_ready === 1'b1 || bus.o_req1_ready === 1'b1) begin
                if (n_gr < 4) gr[n_gr] = bus.o_req1_ready;
                n_gr++;
            end
            if (bus.o_rsp_valid === 1'b1) begin
                checks++;
                if (bus.o_rsp_id !== exp_gr[n_rsp] || bus.o_rsp_result !== (exp_gr[n_rsp] ? 4'd11 : 4'd2)) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: got id=%b res=%0d want id=%b res=%0d", n_rsp, bus.o_rsp_id, bus.o_rsp_result, exp_gr[n_rsp], exp_gr[n_rsp] ? 11 : 2);
                end
                n_rsp++;
                if (n_rsp == 4) begin
                    bus.i_req0_valid = 1'b0;
                    bus.i_req1_valid = 1'b0;
                end
            end
            tick;
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_rsp_ready = 1'b0;
        checks++; if (n_rsp != 4 || n_gr != 4) begin errors++; $display("FAIL rr_counts: got rsp=%0d grants=%0d want 4 4", n_rsp, n_gr); end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (gr[g] !== exp_gr[g]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, gr[g], exp_gr[g]); end
        end
        checks++; if (cnt !== 8'd4 || busy !== 1'b0) begin errors++; $display("FAIL rr_count: got cnt=%0d busy=%b want 4 0", cnt, busy); end
    endtask

    task automatic test_wrap;
        logic [3:0] ta [5] = '{4'd2, 4'd7, 4'd9, 4'd9, 4'd15};
        logic [3:0] tb [5] = '{4'd5, 4'd3, 4'd0, 4'd2, 4'd1};
        logic [1:0] to_ [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
        logic [3:0] tr [5] = '{4'd13, 4'd5, 4'd0, 4'd4, 4'd0};
        logic       td [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] res;
        logic       dz;
        logic       rid;
        bit         tmo;
        for (int v = 0; v < 5; v++) begin
            do_op(1'b1, ta[v], tb[v], to_[v], res, dz, rid, tmo);
            checks++;
            if (tmo || res !== tr[v] || dz !== td[v] || rid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_vec%0d: got tmo=%b res=%0d dz=%b id=%b want 0 %0d %b 1", v, tmo, res, dz, rid, tr[v], td[v]);
            end
        end
    endtask

    task automatic test_backpressure;
        idle_inputs;
        apply_reset;
        bus.i_req0_a = 4'd6; bus.i_req0_b = 4'd2; bus.i_req0_op = 2'b11; bus.i_req0_valid = 1'b1;
        #1;
        checks++; if (bus.o_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", bus.o_req0_ready); end
        tick;
        bus.i_req0_a = 4'd1; bus.i_req0_b = 4'd4; bus.i_req0_op = 2'b00;
        tick;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_result !== 4'd3 || bus.o_rsp_id !== 1'b0 ||
                bus.o_rsp_divzero !== 1'b0 || bus.o_req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got rv=%b res=%0d id=%b dz=%b rdy0=%b want 1 3 0 0 0", c, bus.o_rsp_valid,
                         bus.o_rsp_result, bus.o_rsp_id, bus.o_rsp_divzero, bus.o_req0_ready);
            end
            tick;
        end
        bus.i_rsp_ready = 1'b1;
        #1;
        checks++; if (bus.o_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_no_ready_in_resp: got %b want 0", bus.o_req0_ready); end
        tick;
        checks++; if (cnt !== 8'd1 || bus.o_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs: got cnt=%0d rdy0=%b want 1 1", cnt, bus.o_req0_ready); end
        tick;
        bus.i_req0_valid = 1'b0;
        tick;
        checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_result !== 4'd5) begin errors++; $display("FAIL bp_second: got rv=%b res=%0d want 1 5", bus.o_rsp_valid, bus.o_rsp_result); end
        tick;
        bus.i_rsp_ready = 1'b0;
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", cnt); end
    endtask

    task automatic test_reset_mid;
        idle_inputs;
        apply_reset;
        bus.i_req0_a = 4'd8; bus.i_req0_b = 4'd8; bus.i_req0_op = 2'b00; bus.i_req0_valid = 1'b1;
        tick;
        bus.i_req0_valid = 1'b0;
        tick;
        checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_in_resp: got %b want 1", bus.o_rsp_valid); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (bus.o_rsp_valid !== 1'b0 || cnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got rv=%b cnt=%0d busy=%b want 0 0 0", bus.o_rsp_valid, cnt, busy); end
        bus.i_req0_a = 4'd2; bus.i_req0_b = 4'd3; bus.i_req0_op = 2'b00; bus.i_req0_valid = 1'b1;
        bus.i_req1_a = 4'd4; bus.i_req1_b = 4'd4; bus.i_req1_op = 2'b00; bus.i_req1_valid = 1'b1;
        #1;
        checks++; if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin errors++; $display("FAIL mid_first_grant: got %b%b want 10", bus.o_req0_ready, bus.o_req1_ready); end
        tick;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        tick;
        checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_result !== 4'd5 || bus.o_rsp_id !== 1'b0) begin errors++; $display("FAIL mid_result: got rv=%b res=%0d id=%b want 1 5 0", bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_id); end
        tick;
        bus.i_rsp_ready = 1'b0;
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", cnt); end
    endtask

    task automatic test_count_wrap;
        logic [3:0] res;
        logic       dz;
        logic       rid;
        bit         tmo;
        int         n_to = 0;
        idle_inputs;
        apply_reset;
        for (int k = 0; k < 255; k++) begin
            do_op(k[0], 4'd1, 4'd1, 2'b00, res, dz, rid, tmo);
            if (tmo) n_to++;
        end
        checks++; if (n_to != 0 || cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got cnt=%0d timeouts=%0d want 255 0", cnt, n_to); end
        do_op(1'b0, 4'd1, 4'd1, 2'b00, res, dz, rid, tmo);
        checks++; if (tmo || cnt !== 8'd0) begin errors++; $display("FAIL wrap_256: got cnt=%0d tmo=%b want 0 0", cnt, tmo); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs;
        test_reset;
        test_basic;
        test_round_robin;
        test_wrap;
        test_backpressure;
        test_reset_mid;
        test_count_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
